// File: rtl/uart_pkg.sv
// uart_pkg: shared types and constants for the UART transmit arbiter.
//   arb_state_e      - arbiter FSM states (TAG is used only when UART_ARB_TAG_EN is defined)
//   BYTE_W           - UART byte width
//   TAG_BASE_DEFAULT - default tag byte for requester 0
//   grant_w()        - width of a requester index, never less than 1
package uart_pkg;

    typedef enum logic [1:0] {IDLE, TAG, DATA} arb_state_e;

    localparam int BYTE_W = 8;
    localparam logic [BYTE_W-1:0] TAG_BASE_DEFAULT = 8'h30;

    function automatic int grant_w(input int n);
        return (n > 2) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rr_picker.sv
// rr_picker: combinational rotate-priority encoder for round-robin arbiters.
//   req - request vector (N bits)
//   ptr - index that has the highest priority this cycle
//   idx - first requester with req set, searching upward from ptr with wrap
//   any - at least one request is set
module rr_picker
    import uart_pkg::*;
#(
    parameter int N = 3,
    parameter int W = grant_w(N)
) (
    input  logic [N-1:0] req,
    input  logic [W-1:0] ptr,
    output logic [W-1:0] idx,
    output logic         any
);

    localparam logic [W:0] N_L = (W+1)'(N);

    logic [N-1:0] rot;
    logic [W-1:0] off;
    logic [W:0]   sum;

    // Rotating the request vector right by ptr turns the search into a plain
    // lowest-set-bit priority encode; the offset is then rotated back.
    always_comb begin
        rot = N'({req, req} >> ptr);
        off = '0;
        for (int k = N - 1; k >= 0; k--) begin
            if (rot[k]) off = W'(k);
        end
        sum = {1'b0, ptr} + {1'b0, off};
        idx = (sum >= N_L) ? W'(sum - N_L) : W'(sum);
        any = |req;
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: shares the UART TX FIFO write port among NUM_REQ requesters,
// round-robin at message granularity, with a stall watchdog on the owner.
//   clock, reset_n     - system clock, asynchronous active-low reset
//   req_valid/req_data/req_last/req_ready - per-requester byte handshake
//   tx_fifo_full       - UART TX FIFO full (stalls only)
//   tx_fifo_data_in/tx_fifo_write_en      - registered FIFO write port
//   grant_id, busy     - current owner and message-in-progress flag
//   timeout_pulse      - one-cycle pulse when the watchdog revokes a grant
// Optional feature: define UART_ARB_TAG_EN to prefix each message with the
// owner's tag byte TAG_BASE+grant_id.
module uart_tx_arbiter
    import uart_pkg::*;
#(
    parameter int NUM_REQ = 3,
    parameter int STALL_TIMEOUT = 1024
`ifdef UART_ARB_TAG_EN
    ,
    parameter logic [BYTE_W-1:0] TAG_BASE = TAG_BASE_DEFAULT
`endif
) (
    input  logic                       clock,
    input  logic                       reset_n,
    input  logic [NUM_REQ-1:0]         req_valid,
    input  logic [BYTE_W*NUM_REQ-1:0]  req_data,
    input  logic [NUM_REQ-1:0]         req_last,
    output logic [NUM_REQ-1:0]         req_ready,
    input  logic                       tx_fifo_full,
    output logic [BYTE_W-1:0]          tx_fifo_data_in,
    output logic                       tx_fifo_write_en,
    output logic [2:0]                 grant_id,
    output logic                       busy,
    output logic                       timeout_pulse
);

    localparam int GW = grant_w(NUM_REQ);
    localparam int CW = $clog2(STALL_TIMEOUT);
    localparam logic [CW-1:0] STALL_MAX = CW'(STALL_TIMEOUT - 1);
    localparam logic [GW-1:0] LAST_ID = GW'(NUM_REQ - 1);
    localparam logic [NUM_REQ-1:0] ONE = NUM_REQ'(1);

    arb_state_e        state_q, state_d;
    logic [GW-1:0]     grant_q, grant_d;
    logic [GW-1:0]     rr_ptr_q, rr_ptr_d;
    logic [CW-1:0]     stall_q, stall_d;
    logic              wr_en_q, wr_en_d;
    logic [BYTE_W-1:0] data_q, data_d;
    logic              timeout_q, timeout_d;

    logic [GW-1:0]     pick_idx;
    logic              pick_any;
    logic              slot_ok;
    logic              owner_valid;
    logic              owner_last;
    logic [BYTE_W-1:0] owner_data;
    logic [GW-1:0]     next_ptr;

    rr_picker #(.N(NUM_REQ), .W(GW)) u_picker (
        .req (req_valid),
        .ptr (rr_ptr_q),
        .idx (pick_idx),
        .any (pick_any)
    );

    // A write is never issued right after another, so a full flag that
    // updates one cycle after a write cannot be overrun.
    assign slot_ok     = !tx_fifo_full && !wr_en_q;
    assign owner_valid = req_valid[grant_q];
    assign owner_last  = req_last[grant_q];
    assign owner_data  = req_data[{grant_q, 3'b000} +: BYTE_W];
    assign next_ptr    = (grant_q == LAST_ID) ? '0 : grant_q + 1'b1;

    always_comb begin
        state_d   = state_q;
        grant_d   = grant_q;
        rr_ptr_d  = rr_ptr_q;
        stall_d   = stall_q;
        wr_en_d   = 1'b0;
        data_d    = data_q;
        timeout_d = 1'b0;
        req_ready = '0;
        case (state_q)
            IDLE: begin
                if (pick_any) begin
                    grant_d = pick_idx;
                    stall_d = '0;
`ifdef UART_ARB_TAG_EN
                    state_d = TAG;
`else
                    state_d = DATA;
`endif
                end
            end
`ifdef UART_ARB_TAG_EN
            TAG: begin
                if (slot_ok) begin
                    wr_en_d = 1'b1;
                    data_d  = TAG_BASE + BYTE_W'(grant_q);
                    state_d = DATA;
                end
            end
`endif
            DATA: begin
                req_ready = slot_ok ? ONE << grant_q : '0;
                // Any owner-valid cycle clears the watchdog, even one held
                // off by a full FIFO; a last byte therefore always beats expiry.
                if (owner_valid) begin
                    stall_d = '0;
                    if (slot_ok) begin
                        wr_en_d = 1'b1;
                        data_d  = owner_data;
                        if (owner_last) begin
                            state_d  = IDLE;
                            rr_ptr_d = next_ptr;
                        end
                    end
                end else if (stall_q == STALL_MAX) begin
                    timeout_d = 1'b1;
                    state_d   = IDLE;
                    rr_ptr_d  = next_ptr;
                    stall_d   = '0;
                end else begin
                    stall_d = stall_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= IDLE;
            grant_q   <= '0;
            rr_ptr_q  <= '0;
            stall_q   <= '0;
            wr_en_q   <= 1'b0;
            data_q    <= '0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            grant_q   <= grant_d;
            rr_ptr_q  <= rr_ptr_d;
            stall_q   <= stall_d;
            wr_en_q   <= wr_en_d;
            data_q    <= data_d;
            timeout_q <= timeout_d;
        end
    end

    assign tx_fifo_write_en = wr_en_q;
    assign tx_fifo_data_in  = data_q;
    assign grant_id         = 3'(grant_q);
    assign busy             = (state_q != IDLE);
    assign timeout_pulse    = timeout_q;

endmodule
